ccu_snoop_arbiter: RTL

Shares one ACE snoop master port (AC/CR/CD) between `NoPorts` snoop requesters inside the CCU, such as the write-path and read-path snoop controllers of each snoop path. AC requests are granted round-robin. Grant order is recorded, so CR responses and any following CD bursts go back to the requester that issued the matching AC. The block sits between the snoop paths and the snoop crossbar/demux toward the cached masters. It forwards each granted requester's domain mask and master index alongside its AC.

---
 rtl/ccu_pkg.sv | 50 +++++
 rtl/ccu_snoop_idx_fifo.sv | 58 +++++
 rtl/ccu_snoop_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ccu_pkg.sv
// ---------------------------------------------------------------------------
// ccu_pkg
// Shared types and helpers for the CCU snoop path.
//   ace_snoop_req_t   : requester -> snoop master (AC payload/valid, CR/CD ready)
//   ace_snoop_resp_t  : snoop master -> requester (AC ready, CR, CD)
//   ace_domain_mask_t : snoop target mask forwarded with each AC
//   ace_mst_idx_t     : originating master index forwarded with each AC
//   CrDataTransferBit : bit of cr_resp that announces a following CD burst
//   port_idx_width()  : width of a requester index, never less than 1
// ---------------------------------------------------------------------------
package ccu_pkg;

  localparam int unsigned CrDataTransferBit = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ace_ac_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } ace_cd_chan_t;

  typedef logic [4:0] ace_cr_resp_t;
  typedef logic [2:0] ace_domain_mask_t;
  typedef logic [1:0] ace_mst_idx_t;

  typedef struct packed {
    ace_ac_chan_t ac;
    logic         ac_valid;
    logic         cr_ready;
    logic         cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic         ac_ready;
    ace_cr_resp_t cr_resp;
    logic         cr_valid;
    ace_cd_chan_t cd;
    logic         cd_valid;
  } ace_snoop_resp_t;

  // A single-port index still needs one bit so that typedefs stay legal
  function automatic int unsigned port_idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccu_snoop_idx_fifo.sv
// ---------------------------------------------------------------------------
// ccu_snoop_idx_fifo
// Small FIFO of requester indices used to remember response ordering.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, data : enqueue one entry
//   pop        : dequeue the head entry
//   head       : current head entry (valid while !empty)
//   full/empty : occupancy flags
// A push into an empty FIFO only becomes visible on the next cycle, and a
// push together with a pop is accepted even when the FIFO is full.
// ---------------------------------------------------------------------------
module ccu_snoop_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW:0]   wr_ptr;
  logic [AddrW:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty can be told apart
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                   (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AddrW-1:0]];

  // Pointer update; reset drops every stored entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset, only the pointers decide what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AddrW-1:0]] <= data;
  end

endmodule

// File: rtl/ccu_snoop_arbiter.sv
// ---------------------------------------------------------------------------
// ccu_snoop_arbiter
// Shares one ACE snoop master port between NoPorts snoop requesters.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   slv_snoop_reqs_i   : per-requester AC / cr_ready / cd_ready
//   slv_snoop_resps_o  : per-requester ac_ready / CR / CD
//   slv_masks_i        : per-requester domain mask (qualified by ac_valid)
//   slv_idx_i          : per-requester master index (qualified by ac_valid)
//   mst_snoop_req_o    : shared snoop request toward the crossbar
//   mst_snoop_resp_i   : shared snoop response from the crossbar
//   mst_mask_o         : domain mask of the granted requester
//   mst_idx_o          : master index of the granted requester
// ACs are granted round-robin; the grant order is queued so CRs, and any CD
// bursts announced by them, are steered back to the matching requester.
// ---------------------------------------------------------------------------
module ccu_snoop_arbiter
  import ccu_pkg::*;
#(
  parameter int unsigned NoPorts        = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type snoop_req_t   = ccu_pkg::ace_snoop_req_t,
  parameter type snoop_resp_t  = ccu_pkg::ace_snoop_resp_t,
  parameter type domain_mask_t = ccu_pkg::ace_domain_mask_t,
  parameter type mst_idx_t     = ccu_pkg::ace_mst_idx_t
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  snoop_req_t   slv_snoop_reqs_i  [NoPorts],
  output snoop_resp_t  slv_snoop_resps_o [NoPorts],
  input  domain_mask_t slv_masks_i       [NoPorts],
  input  mst_idx_t     slv_idx_i         [NoPorts],
  output snoop_req_t   mst_snoop_req_o,
  input  snoop_resp_t  mst_snoop_resp_i,
  output domain_mask_t mst_mask_o,
  output mst_idx_t     mst_idx_o
);

  localparam int unsigned IdxW = port_idx_width(NoPorts);
  typedef logic [IdxW-1:0] port_idx_t;

  port_idx_t          rr_ptr;
  port_idx_t          lock_idx;
  port_idx_t          grant;
  port_idx_t          cr_head;
  port_idx_t          cd_head;
  logic               lock_q;
  logic               rst_q;
  logic               blank;
  logic [NoPorts-1:0] ac_valids;
  logic               mst_ac_valid;
  logic               mst_cr_ready;
  logic               mst_cd_ready;
  logic               ac_hs;
  logic               cr_hs;
  logic               cd_hs;
  logic               cr_full;
  logic               cr_empty;
  logic               cd_full;
  logic               cd_empty;
  logic               cr_route;
  logic               cd_route;

  // Valids and readies are held low during reset and for one cycle after it
  assign blank = rst_i || rst_q;

  // Round-robin search starting at rr_ptr; a stalled AC keeps its grant
  always_comb begin
    int  cand;
    logic found;
    cand  = 0;
    found = 1'b0;
    grant = rr_ptr;
    for (int i = 0; i < NoPorts; i++) begin
      ac_valids[i] = slv_snoop_reqs_i[i].ac_valid;
    end
    for (int k = 0; k < NoPorts; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= int'(NoPorts)) cand = cand - int'(NoPorts);
      if (!found && ac_valids[cand]) begin
        grant = port_idx_t'(cand);
        found = 1'b1;
      end
    end
    if (lock_q) grant = lock_idx;
  end

  // No new AC once MaxOutstanding ACs are waiting for their CR
  assign mst_ac_valid = ac_valids[grant] && !cr_full && !blank;
  assign ac_hs        = mst_ac_valid && mst_snoop_resp_i.ac_ready;

  // A CR may only complete when its possible CD order entry has room
  assign cr_route     = !cr_empty && !cd_full && !blank;
  assign cd_route     = !cd_empty && !blank;
  assign mst_cr_ready = cr_route && slv_snoop_reqs_i[cr_head].cr_ready;
  assign mst_cd_ready = cd_route && slv_snoop_reqs_i[cd_head].cd_ready;
  assign cr_hs        = mst_cr_ready && mst_snoop_resp_i.cr_valid;
  assign cd_hs        = mst_cd_ready && mst_snoop_resp_i.cd_valid;

  // Grant lock and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock_q   <= 1'b0;
      lock_idx <= '0;
      rst_q    <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      if (ac_hs) begin
        lock_q <= 1'b0;
        rr_ptr <= (grant == port_idx_t'(NoPorts - 1)) ? '0 : grant + 1'b1;
      end else if (mst_ac_valid) begin
        lock_q   <= 1'b1;
        lock_idx <= grant;
      end
    end
  end

  ccu_snoop_idx_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_cr_order (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (ac_hs),
    .data  (grant),
    .pop   (cr_hs),
    .head  (cr_head),
    .full  (cr_full),
    .empty (cr_empty)
  );

  ccu_snoop_idx_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_cd_order (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (cr_hs && mst_snoop_resp_i.cr_resp[CrDataTransferBit]),
    .data  (cr_head),
    .pop   (cd_hs && mst_snoop_resp_i.cd.last),
    .head  (cd_head),
    .full  (cd_full),
    .empty (cd_empty)
  );

  // Shared master request: AC of the granted port, readies of the FIFO heads
  always_comb begin
    mst_snoop_req_o          = '0;
    mst_snoop_req_o.ac       = slv_snoop_reqs_i[grant].ac;
    mst_snoop_req_o.ac_valid = mst_ac_valid;
    mst_snoop_req_o.cr_ready = mst_cr_ready;
    mst_snoop_req_o.cd_ready = mst_cd_ready;
  end

  assign mst_mask_o = slv_masks_i[grant];
  assign mst_idx_o  = slv_idx_i[grant];

  // Per-requester responses; ports other than the selected one see zeros
  always_comb begin
    for (int i = 0; i < NoPorts; i++) begin
      slv_snoop_resps_o[i]          = '0;
      slv_snoop_resps_o[i].ac_ready = mst_ac_valid && mst_snoop_resp_i.ac_ready &&
                                      (grant == port_idx_t'(i));
      if (cr_route && (cr_head == port_idx_t'(i))) begin
        slv_snoop_resps_o[i].cr_valid = mst_snoop_resp_i.cr_valid;
        slv_snoop_resps_o[i].cr_resp  = mst_snoop_resp_i.cr_resp;
      end
      if (cd_route && (cd_head == port_idx_t'(i))) begin
        slv_snoop_resps_o[i].cd_valid = mst_snoop_resp_i.cd_valid;
        slv_snoop_resps_o[i].cd       = mst_snoop_resp_i.cd;
      end
    end
  end

endmodule
